// File: rtl/approx_err_monitor.sv
// approx_err_monitor: error statistics over a window of approximate-adder samples.
// Optional APPROX_ERR_SQ_EN adds err_sq_sum, the saturating sum of squared errors.
module approx_err_monitor #(
  parameter int W        = 2,
  parameter int WIN_LOG2 = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_y,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] err_sum,
  output logic [W:0]       err_max,
`ifdef APPROX_ERR_SQ_EN
  output logic [CNT_W-1:0] err_sq_sum,
`endif
  output logic             busy,
  output logic             done
);

  localparam int EW  = W + 1;
  localparam int SQW = 2 * EW;
  localparam int AW  = ((CNT_W > SQW) ? CNT_W : SQW) + 1;

  localparam logic [WIN_LOG2:0] WIN =
    {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0] CMAX =
    {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t nstate;

  logic [WIN_LOG2:0] acc_cnt;
  logic              accept;
  logic              start_ok;
  logic              last;

  logic          s1_v;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic [EW-1:0] s1_y;

  logic [EW-1:0] exact;
  logic [EW-1:0] ed;
  logic [AW-1:0] sc_add;
  logic [AW-1:0] ec_add;
  logic [AW-1:0] es_add;

  function automatic logic [CNT_W-1:0] sat(
    input logic [AW-1:0] v
  );
    if (v > AW'(CMAX)) return CMAX;
    return v[CNT_W-1:0];
  endfunction

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) ||
                    (state == DRAIN);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign start_ok = start &&
                    ((state == IDLE) ||
                     (state == DONE));
  assign last     = accept &&
                    ((acc_cnt + 1'b1) == WIN);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start)  nstate = RUN;
      RUN:     if (last)   nstate = DRAIN;
      DRAIN:   if (!s1_v)  nstate = DONE;
      DONE:    if (start)  nstate = RUN;
      default:             nstate = IDLE;
    endcase
    if (clear) nstate = IDLE;
  end

  // Accept counter for the current window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        acc_cnt <= '0;
    else if (clear)    acc_cnt <= '0;
    else if (start_ok) acc_cnt <= '0;
    else if (accept)   acc_cnt <= acc_cnt + 1'b1;
  end

  // Stage 1: capture accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_y <= '0;
    end else begin
      s1_v <= accept && !clear;
      if (accept) begin
        s1_a <= in_a;
        s1_b <= in_b;
        s1_y <= in_y;
      end
    end
  end

  // Stage 2 arithmetic: exact sum and absolute error
  always_comb begin
    exact  = EW'(s1_a) + EW'(s1_b);
    ed     = (exact >= s1_y) ? (exact - s1_y)
                             : (s1_y - exact);
    sc_add = AW'(sample_cnt) + AW'(1'b1);
    ec_add = AW'(err_cnt) + AW'(ed != '0);
    es_add = AW'(err_sum) + AW'(ed);
  end

  // Stage 2: saturating statistics update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      err_sum    <= '0;
      err_max    <= '0;
    end else if (clear || start_ok) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      err_sum    <= '0;
      err_max    <= '0;
    end else if (s1_v) begin
      sample_cnt <= sat(sc_add);
      err_cnt    <= sat(ec_add);
      err_sum    <= sat(es_add);
      if (ed > err_max) err_max <= ed;
    end
  end

`ifdef APPROX_ERR_SQ_EN
  logic [SQW-1:0] sq;
  logic [AW-1:0]  sq_add;

  // Squared error and its saturating sum
  always_comb begin
    sq     = SQW'(ed) * SQW'(ed);
    sq_add = AW'(err_sq_sum) + AW'(sq);
  end

  // Squared-error accumulator, same rules as err_sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_sq_sum <= '0;
    else if (clear || start_ok)  err_sq_sum <= '0;
    else if (s1_v)               err_sq_sum <= sat(sq_add);
  end
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor: scoreboard bench for approx_err_monitor.
// dut_a: WIN_LOG2=2 CNT_W=16; dut_b: WIN_LOG2=5 CNT_W=4.
module tb_approx_err_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       clear;
  logic       in_valid;
  logic [1:0] in_a;
  logic [1:0] in_b;
  logic [2:0] in_y;
  bit         sel;

  logic        a_ready, a_busy, a_done;
  logic [15:0] a_sc, a_ec, a_es;
  logic [2:0]  a_em;
  logic        b_ready, b_busy, b_done;
  logic [3:0]  b_sc, b_ec, b_es;
  logic [2:0]  b_em;

  logic        o_ready, o_busy, o_done;
  logic [15:0] o_sc, o_ec, o_es;
  logic [2:0]  o_em;

`ifdef APPROX_ERR_SQ_EN
  logic [15:0] a_sq;
  logic [3:0]  b_sq;
  logic [15:0] o_sq;
  assign o_sq = sel ? 16'(b_sq) : a_sq;
`endif

  assign o_ready = sel ? b_ready : a_ready;
  assign o_busy  = sel ? b_busy : a_busy;
  assign o_done  = sel ? b_done : a_done;
  assign o_sc    = sel ? 16'(b_sc) : a_sc;
  assign o_ec    = sel ? 16'(b_ec) : a_ec;
  assign o_es    = sel ? 16'(b_es) : a_es;
  assign o_em    = sel ? b_em : a_em;

  approx_err_monitor #(
    .W(2), .WIN_LOG2(2), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(a_ready),
    .in_a(in_a), .in_b(in_b), .in_y(in_y),
    .sample_cnt(a_sc), .err_cnt(a_ec),
    .err_sum(a_es), .err_max(a_em),
`ifdef APPROX_ERR_SQ_EN
    .err_sq_sum(a_sq),
`endif
    .busy(a_busy), .done(a_done)
  );

  approx_err_monitor #(
    .W(2), .WIN_LOG2(5), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(b_ready),
    .in_a(in_a), .in_b(in_b), .in_y(in_y),
    .sample_cnt(b_sc), .err_cnt(b_ec),
    .err_sum(b_es), .err_max(b_em),
`ifdef APPROX_ERR_SQ_EN
    .err_sq_sum(b_sq),
`endif
    .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] sc, ec, es, sq;
    logic [2:0]  em;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_sc, m_ec, m_es, m_em, m_sq;

  // Scoreboard: stats due two edges after the accept was driven
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      n_cmp++;
      if ({o_sc, o_ec, o_es, o_em} !==
          {e.sc, e.ec, e.es, e.em}) begin
        n_bad++;
        $display("FAIL sb_stats: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 o_sc, o_ec, o_es, o_em,
                 e.sc, e.ec, e.es, e.em);
      end
`ifdef APPROX_ERR_SQ_EN
      n_cmp++;
      if (o_sq !== e.sq) begin
        n_bad++;
        $display("FAIL sb_sq: got %0d want %0d",
                 o_sq, e.sq);
      end
`endif
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic model_clear();
    m_sc = 0; m_ec = 0; m_es = 0;
    m_em = 0; m_sq = 0;
    q.delete();
  endtask

  task automatic model_push(input int a, b, y);
    int   ex, ed, lim;
    exp_t e;
    ex  = a + b;
    ed  = (ex >= y) ? ex - y : y - ex;
    lim = sel ? 15 : 65535;
    m_sc = (m_sc + 1 > lim) ? lim : m_sc + 1;
    m_ec = (m_ec + (ed != 0 ? 1 : 0) > lim)
         ? lim : m_ec + (ed != 0 ? 1 : 0);
    m_es = (m_es + ed > lim) ? lim : m_es + ed;
    m_sq = (m_sq + ed * ed > lim)
         ? lim : m_sq + ed * ed;
    if (ed > m_em) m_em = ed;
    e.due = cyc + 2;
    e.sc  = 16'(m_sc);
    e.ec  = 16'(m_ec);
    e.es  = 16'(m_es);
    e.sq  = 16'(m_sq);
    e.em  = 3'(m_em);
    q.push_back(e);
  endtask

  task automatic feed(input int a, b, y);
    bit got;
    got = 0;
    in_a = a[1:0];
    in_b = b[1:0];
    in_y = y[2:0];
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (o_ready) begin
        model_push(a, b, y);
        got = 1;
      end
      cycle();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL feed_timeout: accepted 0 want 1");
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (o_done) ok = 1;
      else cycle();
    end
  endtask

  task automatic restart();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    model_clear();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_y = '0;
    sel = 0;
    model_clear();
    repeat (3) cycle();
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_cmp++;
      if (o_ready !== 1'b0 || o_done !== 1'b0 ||
          o_busy !== 1'b0 ||
          {o_sc, o_ec, o_es, o_em} !== '0) begin
        n_bad++;
        $display("FAIL reset_idle: rdy=%b done=%b busy=%b sc=%0d want 0",
                 o_ready, o_done, o_busy, o_sc);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_window();
    bit ok;
    restart();
    feed(1, 1, 3);
    feed(2, 1, 3);
    feed(3, 3, 7);
    feed(0, 0, 0);
    wait_done(ok);
    n_cmp++;
    if (!ok || {o_sc, o_ec, o_es, o_em} !==
        {16'd4, 16'd2, 16'd2, 3'd1}) begin
      n_bad++;
      $display("FAIL window_stats: done=%b got %0d/%0d/%0d/%0d want 4/2/2/1",
               ok, o_sc, o_ec, o_es, o_em);
    end
`ifdef APPROX_ERR_SQ_EN
    n_cmp++;
    if (o_sq !== 16'd2) begin
      n_bad++;
      $display("FAIL window_sq: got %0d want 2", o_sq);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int acc, last_i, done_i, late;
    restart();
    acc = 0; last_i = -1; done_i = -1; late = 0;
    in_a = 2'd1; in_b = 2'd2; in_y = 3'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (o_ready) begin
        acc++;
        last_i = i;
        if (i >= 4) late++;
        model_push(1, 2, 3);
      end
      cycle();
      if (o_done && done_i < 0) done_i = i;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (acc !== 4) begin
      n_bad++;
      $display("FAIL b2b_accepts: got %0d want 4", acc);
    end
    n_cmp++;
    if (late !== 0) begin
      n_bad++;
      $display("FAIL b2b_ready_late: got %0d want 0", late);
    end
    n_cmp++;
    if (done_i - last_i !== 2) begin
      n_bad++;
      $display("FAIL b2b_done_lat: got %0d want 2",
               done_i - last_i);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int a, b;
    sel = 1;
    restart();
    for (int i = 0; i < 32; i++) begin
      a = i % 4;
      b = (i / 4) % 4;
      feed(a, b, a + b + 1);
    end
    wait_done(ok);
    n_cmp++;
    if (!ok || {o_sc, o_ec, o_es, o_em} !==
        {16'd15, 16'd15, 16'd15, 3'd1}) begin
      n_bad++;
      $display("FAIL sat_stats: done=%b got %0d/%0d/%0d/%0d want 15/15/15/1",
               ok, o_sc, o_ec, o_es, o_em);
    end
`ifdef APPROX_ERR_SQ_EN
    n_cmp++;
    if (o_sq !== 16'd15) begin
      n_bad++;
      $display("FAIL sat_sq: got %0d want 15", o_sq);
    end
`endif
    sel = 0;
  endtask

  task automatic test_clear();
    restart();
    feed(3, 3, 0);
    clear = 1'b1;
    model_clear();
    cycle();
    clear = 1'b0;
    n_cmp++;
    if (o_ready !== 1'b0 || o_busy !== 1'b0 ||
        o_done !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_state: rdy=%b busy=%b done=%b want 0/0/0",
               o_ready, o_busy, o_done);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({o_sc, o_ec, o_es, o_em} !== '0) begin
        n_bad++;
        $display("FAIL clear_stats: got %0d/%0d/%0d/%0d want 0",
                 o_sc, o_ec, o_es, o_em);
      end
      cycle();
    end
  endtask

  task automatic test_restart();
    bit ok;
    restart();
    feed(1, 1, 3);
    feed(2, 1, 3);
    feed(3, 3, 7);
    feed(0, 0, 0);
    wait_done(ok);
    n_cmp++;
    if (!ok || o_sc !== 16'd4 || o_em !== 3'd1) begin
      n_bad++;
      $display("FAIL restart_pre: done=%b sc=%0d em=%0d want 1/4/1",
               ok, o_sc, o_em);
    end
    model_clear();
    start = 1'b1;
    cycle();
    start = 1'b0;
    n_cmp++;
    if ({o_sc, o_ec, o_es, o_em} !== '0 ||
        o_busy !== 1'b1 || o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_zero: sc=%0d busy=%b rdy=%b want 0/1/1",
               o_sc, o_busy, o_ready);
    end
    feed(3, 3, 4);
    feed(1, 2, 3);
    feed(2, 2, 3);
    feed(0, 1, 0);
    wait_done(ok);
    n_cmp++;
    if (!ok || {o_sc, o_ec, o_es, o_em} !==
        {16'd4, 16'd3, 16'd4, 3'd2}) begin
      n_bad++;
      $display("FAIL restart_new: done=%b got %0d/%0d/%0d/%0d want 4/3/4/2",
               ok, o_sc, o_ec, o_es, o_em);
    end
`ifdef APPROX_ERR_SQ_EN
    n_cmp++;
    if (o_sq !== 16'd6) begin
      n_bad++;
      $display("FAIL restart_sq: got %0d want 6", o_sq);
    end
`endif
  endtask

  task automatic test_async_reset();
    restart();
    feed(3, 3, 1);
    cycle();
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (o_busy !== 1'b0 || o_ready !== 1'b0 ||
        {o_sc, o_ec, o_es, o_em} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: busy=%b rdy=%b sc=%0d es=%0d want 0",
               o_busy, o_ready, o_sc, o_es);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_window();
    test_back_to_back();
    test_saturate();
    test_clear();
    test_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
